// File: rtl/fixed_point_divider_seq_if.sv
// -----------------------------------------------------------------------------
// fixed_point_divider_seq_if
// Command/result bundle for the sequential fixed-point divider.
//   master : command source (drives start, a, b; observes results)
//   slave  : divider        (observes start, a, b; drives results)
// Signals:
//   start        request, honoured only while ready=1
//   a, b         unsigned dividend / divisor, sampled on the accepting edge
//   ready        divider idle and able to accept a request
//   done         one-cycle pulse, results valid from this cycle onward
//   quot         integer part of a/b
//   frac         fraction in units of 10^-FRAC_DIGITS (binary coded)
//   div_by_zero  last accepted divisor was zero
// -----------------------------------------------------------------------------
interface fixed_point_divider_seq_if #(
    parameter int WIDTH  = 8,
    parameter int FRAC_W = 10
);
    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ready;
    logic              done;
    logic [WIDTH-1:0]  quot;
    logic [FRAC_W-1:0] frac;
    logic              div_by_zero;

    modport master (
        output start, a, b,
        input  ready, done, quot, frac, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output ready, done, quot, frac, div_by_zero
    );
endinterface

// File: rtl/fixed_point_divider_seq.sv
// -----------------------------------------------------------------------------
// fixed_point_divider_seq
// Sequential unsigned fixed-point divider: a/b -> integer quotient plus a
// FRAC_DIGITS-digit decimal fraction, using shift-subtract restoring division
// with a fixed, data-independent latency.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   dif  fixed_point_divider_seq_if.slave (start/a/b in; ready/done/quot/
//        frac/div_by_zero out)
//
// Optional feature (compile-time macro DIV_ROUND_EN):
//   defined   -> extra ROUND cycle, fraction rounded half-up (carry into quot)
//   undefined -> fraction truncated
//
// Timeline (accepting edge = edge 0):
//   edges 1..WIDTH            integer restoring steps
//   edges WIDTH+1..WIDTH+FRAC_W  fraction restoring steps
//   [+1 ROUND edge]
//   next edge                 DONE: results written, done rises
//   next edge                 done falls, ready rises
// -----------------------------------------------------------------------------
module fixed_point_divider_seq #(
    parameter int WIDTH       = 8,
    parameter int FRAC_DIGITS = 3,
    parameter int FRAC_W      = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    fixed_point_divider_seq_if.slave      dif
);

    // 10^d as an elaboration-time constant
    function automatic int unsigned pow10_f(input int d);
        int unsigned acc;
        acc = 32'd1;
        for (int i = 0; i < d; i++) begin
            acc = acc * 32'd10;
        end
        return acc;
    endfunction

    localparam int          NW      = WIDTH + FRAC_W;
    localparam int          CNT_MAX = (WIDTH > FRAC_W) ? WIDTH : FRAC_W;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned POW10   = pow10_f(FRAC_DIGITS);
    localparam logic [FRAC_W-1:0] POW10_V = FRAC_W'(POW10);

    // r * 10^FRAC_DIGITS as a constant shift-add; no multiplier is inferred
    function automatic logic [NW-1:0] mul_pow10(input logic [WIDTH-1:0] r);
        logic [NW-1:0] acc;
        acc = '0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (POW10_V[i]) begin
                acc = acc + (NW'(r) << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

`ifdef DIV_ROUND_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INT   = 3'd1,
        S_FRAC  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INT   = 3'd1,
        S_FRAC  = 3'd2,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   dvd_r;      // dividend, shifted out MSB first
    logic [WIDTH:0]     rem_r;      // working remainder, always < b between steps
    logic [NW-1:0]      n_r;        // scaled numerator; low FRAC_W bits feed FRAC steps
    logic [WIDTH-1:0]   qw_r;       // working integer quotient
    logic [FRAC_W-1:0]  fw_r;       // working fraction
    logic               dbz_w_r;
    logic               ready_r;
    logic               done_r;
    logic [WIDTH-1:0]   quot_r;
    logic [FRAC_W-1:0]  frac_r;
    logic               dbz_r;

    logic               shift_bit_s;
    logic [WIDTH+1:0]   trial_s;
    logic [WIDTH+1:0]   diff_s;
    logic               fit_s;
    logic [WIDTH:0]     rem_next_s;
    logic [NW-1:0]      n_scaled_s;

    // One restoring step shared by INT and FRAC: shift in next bit, trial-subtract b
    always_comb begin
        if (state_r == S_INT) begin
            shift_bit_s = dvd_r[WIDTH-1];
        end else begin
            shift_bit_s = n_r[FRAC_W-1];
        end
        trial_s = {rem_r, shift_bit_s};
        diff_s  = trial_s - {2'b00, b_r};
        // no borrow out of the subtraction means the divisor fits
        fit_s   = ~diff_s[WIDTH+1];
        if (fit_s) begin
            rem_next_s = diff_s[WIDTH:0];
        end else begin
            rem_next_s = trial_s[WIDTH:0];
        end
        n_scaled_s = mul_pow10(rem_next_s[WIDTH-1:0]);
    end

`ifdef DIV_ROUND_EN
    logic [WIDTH+1:0]  twice_rem_s;
    logic              round_up_s;
    logic [FRAC_W:0]   frac_inc_s;

    // Half-up decision from the final remainder N mod b
    always_comb begin
        twice_rem_s = {rem_r, 1'b0};
        round_up_s  = (twice_rem_s >= {2'b00, b_r});
        frac_inc_s  = {1'b0, fw_r} + {{FRAC_W{1'b0}}, 1'b1};
    end
`endif

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            b_r     <= '0;
            dvd_r   <= '0;
            rem_r   <= '0;
            n_r     <= '0;
            qw_r    <= '0;
            fw_r    <= '0;
            dbz_w_r <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            quot_r  <= '0;
            frac_r  <= '0;
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (!ready_r) begin
                        // first idle cycle after DONE: done drops, ready returns
                        ready_r <= 1'b1;
                    end else if (dif.start) begin
                        ready_r <= 1'b0;
                        b_r     <= dif.b;
                        dvd_r   <= dif.a;
                        rem_r   <= '0;
                        cnt_r   <= '0;
                        qw_r    <= '0;
                        fw_r    <= '0;
                        if (dif.b == {WIDTH{1'b0}}) begin
                            dbz_w_r <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            dbz_w_r <= 1'b0;
                            state_r <= S_INT;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end

                S_INT: begin
                    dvd_r <= dvd_r << 1;
                    qw_r  <= {qw_r[WIDTH-2:0], fit_s};
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        // integer part finished: seed the fraction stage with
                        // r*10^k; its top WIDTH bits are already < b
                        cnt_r   <= '0;
                        n_r     <= n_scaled_s;
                        rem_r   <= {1'b0, n_scaled_s[NW-1:FRAC_W]};
                        state_r <= S_FRAC;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        rem_r <= rem_next_s;
                    end
                end

                S_FRAC: begin
                    n_r   <= n_r << 1;
                    fw_r  <= {fw_r[FRAC_W-2:0], fit_s};
                    rem_r <= rem_next_s;
                    if (cnt_r == CNT_W'(FRAC_W - 1)) begin
                        cnt_r <= '0;
`ifdef DIV_ROUND_EN
                        state_r <= S_ROUND;
`else
                        state_r <= S_DONE;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

`ifdef DIV_ROUND_EN
                S_ROUND: begin
                    if (round_up_s) begin
                        if (frac_inc_s == {1'b0, POW10_V}) begin
                            // fraction wrapped to 1.000: carry into quot
                            fw_r <= '0;
                            qw_r <= qw_r + WIDTH'(1);
                        end else begin
                            fw_r <= frac_inc_s[FRAC_W-1:0];
                        end
                    end else begin
                        fw_r <= fw_r;
                    end
                    state_r <= S_DONE;
                end
`endif

                S_DONE: begin
                    done_r  <= 1'b1;
                    state_r <= S_IDLE;
                    if (dbz_w_r) begin
                        quot_r <= {WIDTH{1'b1}};
                        frac_r <= '0;
                        dbz_r  <= 1'b1;
                    end else begin
                        quot_r <= qw_r;
                        frac_r <= fw_r;
                        dbz_r  <= 1'b0;
                    end
                end

                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dif.ready       = ready_r;
    assign dif.done        = done_r;
    assign dif.quot        = quot_r;
    assign dif.frac        = frac_r;
    assign dif.div_by_zero = dbz_r;

endmodule
